// File: rtl/nibble_serial_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding and slice width.
package nibble_serial_sub_pkg;
   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;
endpackage

// File: rtl/nibble_serial_sub_bit4_bla.sv
// bit4_bla: 4-bit borrow-lookahead subtract slice, D = X - Y - Bin.
module bit4_bla
   import nibble_serial_sub_pkg::*;
(
   input  logic [SLICE_W-1:0] X,
   input  logic [SLICE_W-1:0] Y,
   input  logic               Bin,
   output logic [SLICE_W-1:0] D,
   output logic               Bout,
   output logic               G,
   output logic               P
);
   logic [SLICE_W-1:0] g, p;
   logic [SLICE_W-1:0] brw;

   // g: this bit borrows on its own; p: this bit passes an incoming borrow on
   assign g = ~X & Y;
   assign p = ~X | Y;

   assign brw[0] = Bin;
   assign brw[1] = g[0] | (p[0] & Bin);
   assign brw[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Bin);
   assign brw[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Bin);

   assign G    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign P    = &p;
   assign Bout = G | (P & Bin);
   assign D    = X ^ Y ^ brw;
endmodule

// File: rtl/nibble_serial_sub.sv
// Nibble-serial WIDTH-bit subtractor: D = A - B - Bin, one 4-bit slice per RUN cycle,
// valid/ready in and out, borrow carried between nibbles in a register.
module nibble_serial_sub
   import nibble_serial_sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             Ovf,
   output logic             Zero,
   output logic             busy
);
   localparam int NIBBLES = WIDTH / SLICE_W;
   localparam int CW      = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
   logic             brw_q, brw_d, bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

   logic [SLICE_W-1:0] a_nib, b_nib, d_nib;
   logic               nib_bout;
   logic [WIDTH-1:0]   d_full;
   logic               accept;

   assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign D         = d_q;
   assign Bout      = bout_q;
   assign Ovf       = ovf_q;
   assign Zero      = zero_q;

   assign a_nib = a_q[cnt_q*SLICE_W +: SLICE_W];
   assign b_nib = b_q[cnt_q*SLICE_W +: SLICE_W];

   bit4_bla u_slice (
      .X    (a_nib),
      .Y    (b_nib),
      .Bin  (brw_q),
      .D    (d_nib),
      .Bout (nib_bout),
      .G    (),
      .P    ()
   );

   // Result as it will look once this cycle's nibble lands; flags are taken from it on the last slice
   always_comb begin
      d_full = d_q;
      d_full[cnt_q*SLICE_W +: SLICE_W] = d_nib;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      d_d     = d_q;
      brw_d   = brw_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = A;
               b_d     = B;
               brw_d   = Bin;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            d_d   = d_full;
            brw_d = nib_bout;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
               bout_d  = nib_bout;
               zero_d  = (d_full == '0);
               ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (d_full[WIDTH-1] ^ a_q[WIDTH-1]);
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  a_d     = A;
                  b_d     = B;
                  brw_d   = Bin;
                  cnt_d   = '0;
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         d_q     <= '0;
         brw_q   <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         d_q     <= d_d;
         brw_q   <= brw_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Self-checking bench for nibble_serial_sub (WIDTH=16): directed vectors, backpressure,
// async reset mid-operation and randomized ops against an arithmetic reference.
module tb_nibble_serial_sub;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready;
   logic [W-1:0] A, B, D;
   logic         Bin, out_valid, out_ready, Bout, Ovf, Zero, busy;

   int errors = 0;
   int checks = 0;

   nibble_serial_sub #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
      .D(D), .Bout(Bout), .Ovf(Ovf), .Zero(Zero), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference: full-precision A - B - Bin; a negative result sets bit W.
   function automatic logic [W+3:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      logic [W:0] r;
      logic       ov;
      r  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
      ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      return {r[W], ov, (r[W-1:0] == 0), 1'b0, r[W-1:0]};
   endfunction

   // Issue one op from IDLE with out_ready low; returns edges from handshake to out_valid.
   task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, output int lat);
      @(negedge clk);
      A = a; B = b; Bin = bi; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (D !== 16'h0000) begin errors++; $display("FAIL rst_D got=%h exp=0000", D); end
      checks++; if ({Bout, Ovf, Zero} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {Bout, Ovf, Zero}); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle got in_ready=%b busy=%b exp 1/0", in_ready, busy); end
   endtask

   task automatic test_directed();
      // a, b, bin, expected D, Bout, Ovf, Zero
      logic [W-1:0] va [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'h5555, 16'hABCD};
      logic [W-1:0] vb [6] = '{16'h0234, 16'h0001, 16'h0001, 16'hFFFF, 16'h5554, 16'hABCD};
      logic         vi [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [W-1:0] ed [6] = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
      logic [2:0]   ef [6] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b100};
      int lat;
      for (int i = 0; i < 6; i++) begin
         issue_op(va[i], vb[i], vi[i], lat);
         checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=4", i, lat); end
         checks++; if (D !== ed[i]) begin errors++; $display("FAIL dir%0d_D got=%h exp=%h", i, D, ed[i]); end
         checks++; if ({Bout, Ovf, Zero} !== ef[i]) begin errors++; $display("FAIL dir%0d_flags(BOZ) got=%b exp=%b", i, {Bout, Ovf, Zero}, ef[i]); end
         consume();
      end
      // A=0, B=all-ones, Bin=1 wraps to exactly zero with a borrow
      issue_op(16'h0000, 16'hFFFF, 1'b1, lat);
      checks++; if (D !== 16'h0000 || {Bout, Ovf, Zero} !== 3'b101) begin errors++; $display("FAIL dir_wrap got D=%h BOZ=%b exp 0000/101", D, {Bout, Ovf, Zero}); end
      consume();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dir_idle_after got ov=%b busy=%b exp 0/0", out_valid, busy); end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [W+3:0] e;
      issue_op(16'h1234, 16'h1111, 1'b0, lat);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || D !== 16'h0123 || {Bout, Ovf, Zero} !== 3'b000) begin
            errors++;
            $display("FAIL bp_hold%0d got ov=%b ir=%b D=%h BOZ=%b exp 1/0/0123/000", c, out_valid, in_ready, D, {Bout, Ovf, Zero});
         end
      end
      // consume and issue in the same edge
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; A = 16'h4000; B = 16'h0001; Bin = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_b2b_run got busy=%b ov=%b ir=%b exp 1/0/0", busy, out_valid, in_ready); end
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         if (lat < 3) begin
            in_valid = 1'($urandom_range(0, 1)); A = W'($urandom); B = W'($urandom); Bin = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      e = ref_sub(16'h4000, 16'h0001, 1'b0);
      checks++; if (lat !== 4) begin errors++; $display("FAIL bp_b2b_latency got=%0d exp=4", lat); end
      checks++; if (D !== e[W-1:0] || {Bout, Ovf, Zero} !== e[W+3:W+1]) begin errors++; $display("FAIL bp_b2b_result got D=%h BOZ=%b exp %h/%b", D, {Bout, Ovf, Zero}, e[W-1:0], e[W+3:W+1]); end
      consume();
   endtask

   task automatic test_midrun_reset();
      int lat;
      @(negedge clk);
      A = 16'h0F0F; B = 16'h0101; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || D !== 16'h0000) begin errors++; $display("FAIL mr_async got ov=%b busy=%b D=%h exp 0/0/0000", out_valid, busy, D); end
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_stale%0d got ov=%b exp=0", c, out_valid); end
      end
      out_ready = 1'b0;
      issue_op(16'h0010, 16'h0001, 1'b0, lat);
      checks++; if (lat !== 4 || D !== 16'h000F) begin errors++; $display("FAIL mr_fresh got lat=%0d D=%h exp 4/000F", lat, D); end
      consume();
   endtask

   task automatic test_random();
      int lat;
      logic [W-1:0] a, b;
      logic         bi;
      logic [W+3:0] e;
      for (int n = 0; n < 2000; n++) begin
         a  = W'($urandom);
         b  = W'($urandom);
         bi = 1'($urandom_range(0, 1));
         if (n % 8 == 0) b = a;
         e = ref_sub(a, b, bi);
         issue_op(a, b, bi, lat);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         checks++; if (lat !== 4) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=4", n, lat); end
         checks++; if (D !== e[W-1:0]) begin errors++; $display("FAIL rnd%0d_D a=%h b=%h bin=%b got=%h exp=%h", n, a, b, bi, D, e[W-1:0]); end
         checks++; if (Bout !== e[W+3]) begin errors++; $display("FAIL rnd%0d_Bout got=%b exp=%b", n, Bout, e[W+3]); end
         checks++; if (Ovf !== e[W+2]) begin errors++; $display("FAIL rnd%0d_Ovf got=%b exp=%b", n, Ovf, e[W+2]); end
         checks++; if (Zero !== e[W+1]) begin errors++; $display("FAIL rnd%0d_Zero got=%b exp=%b", n, Zero, e[W+1]); end
         consume();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_midrun_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
